ltm_timing_gen: RTL and testbench

Timing generator for the 800x480 LTM panel path. It produces the panel sync strobes (`hd`, `vd`), the data-enable `den`, and the active-pixel coordinates on the LCD pixel clock. It sits directly upstream of the DEN-driven coordinate tracker and the pixel/blending logic: its `den` drives that tracker's DEN input, and its `x`/`y` give the same coordinates directly.

---
 rtl/ltm_timing_pkg.sv | 33 +++
 rtl/ltm_axis_counter.sv | 56 +++++
 rtl/ltm_timing_gen.sv | 95 +++++++++
 tb/tb_ltm_timing_gen.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltm_timing_pkg.sv
// Shared timing constants, axis state encoding and coordinate width for the
// 800x480 LTM panel timing generator.
package ltm_timing_pkg;

    localparam int COORD_W   = 11;
    localparam int COORD_MAX = (1 << COORD_W) - 1;

    localparam int DEF_H_SYNC   = 30;
    localparam int DEF_H_BP     = 16;
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 210;
    localparam int DEF_H_TOTAL  = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;

    localparam int DEF_V_SYNC   = 13;
    localparam int DEF_V_BP     = 10;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 22;
    localparam int DEF_V_TOTAL  = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

    typedef logic [1:0] axis_state_t;

    localparam axis_state_t ST_SYNC   = 2'd0;
    localparam axis_state_t ST_BACK   = 2'd1;
    localparam axis_state_t ST_ACTIVE = 2'd2;
    localparam axis_state_t ST_FRONT  = 2'd3;

    // A segment set is usable only if no segment is empty and the whole
    // period still fits in the coordinate width.
    function automatic bit params_legal(input int s, input int b, input int a, input int f);
        return (s > 0) && (b > 0) && (a > 0) && (f > 0) && ((s + b + a + f) <= COORD_MAX);
    endfunction

endpackage

// File: rtl/ltm_axis_counter.sv
// One timing axis: walks SYNC -> BACK -> ACTIVE -> FRONT, each segment lasting
// its parameter length, with a sub-count that restarts on every segment change.
module ltm_axis_counter
    import ltm_timing_pkg::*;
#(
    parameter int SYNC   = 1,
    parameter int BP     = 1,
    parameter int ACTIVE = 1,
    parameter int FP     = 1
) (
    input  logic               clk_lcd,
    input  logic               reset,
    input  logic               tick,
    output axis_state_t        state,
    output logic [COORD_W-1:0] sub_cnt,
    output logic               wrap
);

    if (!params_legal(SYNC, BP, ACTIVE, FP)) begin : g_bad_params
        $error("ltm_axis_counter: segment lengths must be nonzero and total at most %0d",
               COORD_MAX);
    end

    logic [COORD_W-1:0] last_idx;
    logic               at_last;

    always_comb begin
        last_idx = COORD_W'(SYNC - 1);
        case (state)
            ST_SYNC:   last_idx = COORD_W'(SYNC - 1);
            ST_BACK:   last_idx = COORD_W'(BP - 1);
            ST_ACTIVE: last_idx = COORD_W'(ACTIVE - 1);
            ST_FRONT:  last_idx = COORD_W'(FP - 1);
            default:   last_idx = COORD_W'(SYNC - 1);
        endcase
    end

    assign at_last = (sub_cnt == last_idx);
    assign wrap    = tick && (state == ST_FRONT) && at_last;

    // The 2-bit state rolls from FRONT back to SYNC on its own.
    always_ff @(posedge clk_lcd or posedge reset) begin
        if (reset) begin
            state   <= ST_SYNC;
            sub_cnt <= '0;
        end else if (tick) begin
            if (at_last) begin
                state   <= state + 2'd1;
                sub_cnt <= '0;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ltm_timing_gen.sv
// LTM panel timing generator: chains a horizontal and a vertical axis counter
// and registers the sync, data-enable, coordinate and pulse outputs from them.
module ltm_timing_gen
    import ltm_timing_pkg::*;
#(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP
) (
    input  logic               clk_lcd,
    input  logic               reset,
    input  logic               en,
    output logic               hd,
    output logic               vd,
    output logic               den,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start,
    output logic               line_end
);

    axis_state_t        h_state;
    axis_state_t        v_state;
    logic [COORD_W-1:0] h_sub;
    logic [COORD_W-1:0] v_sub;
    logic               h_wrap;
    logic               v_wrap;
    logic               v_tick;
    logic               den_c;

    assign v_tick = en && h_wrap;

    ltm_axis_counter #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP)
    ) u_h_axis (
        .clk_lcd (clk_lcd),
        .reset   (reset),
        .tick    (en),
        .state   (h_state),
        .sub_cnt (h_sub),
        .wrap    (h_wrap)
    );

    ltm_axis_counter #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP)
    ) u_v_axis (
        .clk_lcd (clk_lcd),
        .reset   (reset),
        .tick    (v_tick),
        .state   (v_state),
        .sub_cnt (v_sub),
        .wrap    (v_wrap)
    );

    assign den_c = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);

    // Outputs are decoded from the pre-edge counter state, so they trail the
    // counters by one clock; pulses are cleared rather than held while paused.
    always_ff @(posedge clk_lcd or posedge reset) begin
        if (reset) begin
            hd          <= 1'b1;
            vd          <= 1'b1;
            den         <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else if (en) begin
            hd          <= (h_state != ST_SYNC);
            vd          <= (v_state != ST_SYNC);
            den         <= den_c;
            if (den_c) begin
                x <= h_sub;
                y <= v_sub;
            end
            frame_start <= den_c && (h_sub == '0) && (v_sub == '0);
            line_end    <= den_c && (h_sub == COORD_W'(H_ACTIVE - 1));
        end else begin
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ltm_timing_gen.sv
// Self-checking bench: a reduced-timing instance and a default-timing instance
// are run side by side against a position-arithmetic reference model.
module tb_ltm_timing_gen;
    import ltm_timing_pkg::*;

    localparam int SHS = 5;
    localparam int SHB = 3;
    localparam int SHA = 16;
    localparam int SHF = 6;
    localparam int SVS = 3;
    localparam int SVB = 2;
    localparam int SVA = 6;
    localparam int SVF = 2;
    localparam int SHT    = SHS + SHB + SHA + SHF;
    localparam int SVT    = SVS + SVB + SVA + SVF;
    localparam int SFRAME = SHT * SVT;
    localparam int SFIRST = (SVS + SVB) * SHT + SHS + SHB + 1;
    localparam int DFIRST = (DEF_V_SYNC + DEF_V_BP) * DEF_H_TOTAL + DEF_H_SYNC + DEF_H_BP + 1;

    typedef struct packed {
        logic        hd;
        logic        vd;
        logic        den;
        logic [10:0] x;
        logic [10:0] y;
        logic        fs;
        logic        le;
    } out_t;

    localparam out_t RST = '{hd: 1'b1, vd: 1'b1, den: 1'b0, x: 11'd0, y: 11'd0, fs: 1'b0, le: 1'b0};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b0;

    logic        hd_s, vd_s, den_s, fs_s, le_s;
    logic [10:0] x_s, y_s;
    logic        hd_d, vd_d, den_d, fs_d, le_d;
    logic [10:0] x_d, y_d;

    out_t act_s, act_d, exp_s, exp_d;
    int   p_s, p_d;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ltm_timing_gen #(
        .H_SYNC (SHS), .H_BP (SHB), .H_ACTIVE (SHA), .H_FP (SHF),
        .V_SYNC (SVS), .V_BP (SVB), .V_ACTIVE (SVA), .V_FP (SVF)
    ) dut_small (
        .clk_lcd     (clk),
        .reset       (reset),
        .en          (en),
        .hd          (hd_s),
        .vd          (vd_s),
        .den         (den_s),
        .x           (x_s),
        .y           (y_s),
        .frame_start (fs_s),
        .line_end    (le_s)
    );

    ltm_timing_gen dut_def (
        .clk_lcd     (clk),
        .reset       (reset),
        .en          (en),
        .hd          (hd_d),
        .vd          (vd_d),
        .den         (den_d),
        .x           (x_d),
        .y           (y_d),
        .frame_start (fs_d),
        .line_end    (le_d)
    );

    assign act_s = {hd_s, vd_s, den_s, x_s, y_s, fs_s, le_s};
    assign act_d = {hd_d, vd_d, den_d, x_d, y_d, fs_d, le_d};

    // Expected outputs for the p-th enabled clock since reset, from the raster
    // position alone: column p mod line length, line (p div line length) mod frame.
    function automatic out_t decode(input int p, input int hs, input int hb, input int ha,
                                    input int hf, input int vs, input int vb, input int va,
                                    input int vf, input out_t prev);
        int   ht, vt, hp, vl;
        logic act;
        out_t o;
        ht    = hs + hb + ha + hf;
        vt    = vs + vb + va + vf;
        hp    = p % ht;
        vl    = (p / ht) % vt;
        act   = (hp >= hs + hb) && (hp < hs + hb + ha) && (vl >= vs + vb) && (vl < vs + vb + va);
        o.hd  = (hp >= hs);
        o.vd  = (vl >= vs);
        o.den = act;
        o.x   = act ? 11'(hp - hs - hb) : prev.x;
        o.y   = act ? 11'(vl - vs - vb) : prev.y;
        o.fs  = act && (hp == hs + hb) && (vl == vs + vb);
        o.le  = act && (hp == hs + hb + ha - 1);
        return o;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p_s   <= 0;
            p_d   <= 0;
            exp_s <= RST;
            exp_d <= RST;
        end else if (en) begin
            exp_s <= decode(p_s, SHS, SHB, SHA, SHF, SVS, SVB, SVA, SVF, exp_s);
            exp_d <= decode(p_d, DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP,
                            DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP, exp_d);
            p_s   <= p_s + 1;
            p_d   <= p_d + 1;
        end else begin
            exp_s.fs <= 1'b0;
            exp_s.le <= 1'b0;
            exp_d.fs <= 1'b0;
            exp_d.le <= 1'b0;
        end
    end

    task automatic test_reset();
        #1;
        en    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (act_s !== RST) begin
            miscompares++;
            $display("[TB] FAIL reset_small: got %h expected %h", act_s, RST);
        end
        vectors++;
        if (act_d !== RST) begin
            miscompares++;
            $display("[TB] FAIL reset_default: got %h expected %h", act_d, RST);
        end
    endtask

    task automatic test_default_timing();
        int          bad = 0;
        int          first_den = 0;
        logic [53:0] fa = '0;
        logic [53:0] fe = '0;
        reset = 1'b0;
        for (int e = 1; e <= DFIRST + DEF_H_ACTIVE; e++) begin
            @(negedge clk);
            if ({act_s, act_d} !== {exp_s, exp_d}) begin
                if (bad == 0) begin fa = {act_s, act_d}; fe = {exp_s, exp_d}; end
                bad++;
            end
            if (den_d && first_den == 0) first_den = e;
            if (e == 1 || e == DEF_H_SYNC || e == DEF_H_TOTAL + 1) begin
                vectors++;
                if (hd_d !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL hd_low edge %0d: got %b expected 0", e, hd_d);
                end
            end
            if (e == DEF_H_SYNC + 1 || e == DEF_H_TOTAL) begin
                vectors++;
                if (hd_d !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL hd_high edge %0d: got %b expected 1", e, hd_d);
                end
            end
            if (e == DEF_V_SYNC * DEF_H_TOTAL) begin
                vectors++;
                if (vd_d !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL vd_low edge %0d: got %b expected 0", e, vd_d);
                end
            end
            if (e == DEF_V_SYNC * DEF_H_TOTAL + 1) begin
                vectors++;
                if (vd_d !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL vd_high edge %0d: got %b expected 1", e, vd_d);
                end
            end
            if (e == DFIRST) begin
                vectors++;
                if ({den_d, fs_d, x_d, y_d} !== {1'b1, 1'b1, 11'd0, 11'd0}) begin
                    miscompares++;
                    $display("[TB] FAIL first_pixel: got den=%b fs=%b x=%0d y=%0d expected den=1 fs=1 x=0 y=0",
                             den_d, fs_d, x_d, y_d);
                end
            end
            if (e == DFIRST + DEF_H_ACTIVE - 1) begin
                vectors++;
                if ({den_d, le_d, x_d} !== {1'b1, 1'b1, 11'd799}) begin
                    miscompares++;
                    $display("[TB] FAIL first_line_end: got den=%b le=%b x=%0d expected den=1 le=1 x=799",
                             den_d, le_d, x_d);
                end
            end
            if (e == DFIRST + DEF_H_ACTIVE) begin
                vectors++;
                if (den_d !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL den_after_line: got %b expected 0", den_d);
                end
            end
        end
        vectors++;
        if (first_den != DFIRST) begin
            miscompares++;
            $display("[TB] FAIL first_den_edge: got %0d expected %0d", first_den, DFIRST);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL default_run_model: %0d bad cycles, first got %h expected %h", bad, fa, fe);
        end
    endtask

    task automatic test_en_gap();
        int          bad = 0;
        int          hold_bad = 0;
        int          dens = 0;
        int          les = 0;
        int          le_x_bad = 0;
        bit          found = 0;
        bit          done = 0;
        logic [53:0] fa = '0;
        logic [53:0] fe = '0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if ({act_s, act_d} !== {exp_s, exp_d}) begin
                if (bad == 0) begin fa = {act_s, act_d}; fe = {exp_s, exp_d}; end
                bad++;
            end
            if (den_d && x_d == 11'd400) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("[TB] FAIL en_gap_wait: got no x=400 within budget expected x=400");
        end
        en = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if ({act_s, act_d} !== {exp_s, exp_d}) begin
                if (bad == 0) begin fa = {act_s, act_d}; fe = {exp_s, exp_d}; end
                bad++;
            end
            if ({den_d, x_d, le_d, fs_d} !== {1'b1, 11'd400, 1'b0, 1'b0}) hold_bad++;
        end
        vectors++;
        if (hold_bad != 0) begin
            miscompares++;
            $display("[TB] FAIL en_hold: got %0d drifting cycles expected 0", hold_bad);
        end
        en = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if ({act_s, act_d} !== {exp_s, exp_d}) begin
                if (bad == 0) begin fa = {act_s, act_d}; fe = {exp_s, exp_d}; end
                bad++;
            end
            if (!den_d) begin
                done = 1;
            end else begin
                dens++;
                if (le_d) begin
                    les++;
                    if (x_d !== 11'd799) le_x_bad++;
                end
            end
        end
        vectors++;
        if (dens != 399) begin
            miscompares++;
            $display("[TB] FAIL en_resume_den: got %0d expected 399", dens);
        end
        vectors++;
        if (les != 1 || le_x_bad != 0) begin
            miscompares++;
            $display("[TB] FAIL en_resume_line_end: got %0d pulses (%0d off x=799) expected 1",
                     les, le_x_bad);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL en_gap_model: %0d bad cycles, first got %h expected %h", bad, fa, fe);
        end
    endtask

    task automatic test_random_en();
        int          bad = 0;
        logic [53:0] fa = '0;
        logic [53:0] fe = '0;
        for (int i = 0; i < 3 * SFRAME; i++) begin
            @(negedge clk);
            if ({act_s, act_d} !== {exp_s, exp_d}) begin
                if (bad == 0) begin fa = {act_s, act_d}; fe = {exp_s, exp_d}; end
                bad++;
            end
            en = ($urandom_range(0, 3) != 0);
        end
        en = 1'b1;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL random_en_model: %0d bad cycles, first got %h expected %h", bad, fa, fe);
        end
    endtask

    task automatic test_two_frames();
        int          bad = 0;
        int          dens = 0;
        int          les = 0;
        int          le_x_bad = 0;
        int          y_bad = 0;
        int          fs_cnt = 0;
        int          fs_e[2] = '{0, 0};
        int          last_y = -1;
        logic [53:0] fa = '0;
        logic [53:0] fe = '0;
        en    = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= SFIRST + 2 * SFRAME - 1; e++) begin
            @(negedge clk);
            if ({act_s, act_d} !== {exp_s, exp_d}) begin
                if (bad == 0) begin fa = {act_s, act_d}; fe = {exp_s, exp_d}; end
                bad++;
            end
            if (den_s) dens++;
            if (fs_s) begin
                if (fs_cnt < 2) fs_e[fs_cnt] = e;
                fs_cnt++;
            end
            if (le_s) begin
                if (x_s !== 11'(SHA - 1)) le_x_bad++;
                if (y_s !== 11'(les % SVA)) y_bad++;
                last_y = int'(y_s);
                les++;
            end
        end
        vectors++;
        if (dens != 2 * SVA * SHA) begin
            miscompares++;
            $display("[TB] FAIL frames_den_count: got %0d expected %0d", dens, 2 * SVA * SHA);
        end
        vectors++;
        if (les != 2 * SVA || le_x_bad != 0) begin
            miscompares++;
            $display("[TB] FAIL frames_line_end: got %0d pulses (%0d off last column) expected %0d",
                     les, le_x_bad, 2 * SVA);
        end
        vectors++;
        if (fs_cnt != 2 || fs_e[0] != SFIRST || fs_e[1] != SFIRST + SFRAME) begin
            miscompares++;
            $display("[TB] FAIL frames_start_edges: got %0d pulses at %0d,%0d expected 2 at %0d,%0d",
                     fs_cnt, fs_e[0], fs_e[1], SFIRST, SFIRST + SFRAME);
        end
        vectors++;
        if (y_bad != 0 || last_y != SVA - 1) begin
            miscompares++;
            $display("[TB] FAIL frames_y_sequence: got %0d bad rows, last y=%0d expected 0 bad, last y=%0d",
                     y_bad, last_y, SVA - 1);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL frames_model: %0d bad cycles, first got %h expected %h", bad, fa, fe);
        end
    endtask

    // Downstream tracker behaviour: count_x counts consecutive DEN-high cycles,
    // the row counter steps on every DEN fall and clears at frame start.
    task automatic test_tracker();
        int   tx = 0;
        int   rows = 0;
        int   lines = 0;
        int   tx_bad = 0;
        int   row_bad = 0;
        logic prev_den = 1'b0;
        for (int i = 0; i < SFRAME; i++) begin
            @(negedge clk);
            if (fs_s) rows = 0;
            if (prev_den && !den_s) rows++;
            tx = den_s ? tx + 1 : 0;
            if (den_s && tx != int'(x_s) + 1) tx_bad++;
            if (le_s) begin
                if (rows != int'(y_s)) row_bad++;
                lines++;
            end
            prev_den = den_s;
        end
        vectors++;
        if (tx_bad != 0) begin
            miscompares++;
            $display("[TB] FAIL tracker_count_x: got %0d cycles with count_x != x+1 expected 0", tx_bad);
        end
        vectors++;
        if (row_bad != 0 || rows != SVA || lines != SVA) begin
            miscompares++;
            $display("[TB] FAIL tracker_rows: got rows=%0d lines=%0d bad=%0d expected rows=%0d lines=%0d bad=0",
                     rows, lines, row_bad, SVA, SVA);
        end
    endtask

    task automatic test_reset_midframe();
        int          bad = 0;
        int          hd_bad = 0;
        int          early = 0;
        int          tx_t;
        int          ty_t;
        bit          found = 0;
        logic [53:0] fa = '0;
        logic [53:0] fe = '0;
        tx_t = int'($urandom_range(1, SHA - 2));
        ty_t = int'($urandom_range(1, SVA - 2));
        for (int i = 0; i < 2 * SFRAME && !found; i++) begin
            @(negedge clk);
            if (den_s && int'(x_s) == tx_t && int'(y_s) == ty_t) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("[TB] FAIL midframe_wait: got no x=%0d y=%0d within budget", tx_t, ty_t);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({hd_s, vd_s, den_s} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL midframe_async: got hd=%b vd=%b den=%b expected hd=1 vd=1 den=0",
                     hd_s, vd_s, den_s);
        end
        vectors++;
        if ({act_s, act_d} !== {RST, RST}) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset_values: got %h expected %h", {act_s, act_d}, {RST, RST});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= SFIRST; e++) begin
            @(negedge clk);
            if ({act_s, act_d} !== {exp_s, exp_d}) begin
                if (bad == 0) begin fa = {act_s, act_d}; fe = {exp_s, exp_d}; end
                bad++;
            end
            if (hd_s !== ((e % SHT) > SHS || (e % SHT) == 0)) hd_bad++;
            if (e < SFIRST && den_s) early++;
            if (e == SFIRST) begin
                vectors++;
                if ({den_s, fs_s, x_s, y_s} !== {1'b1, 1'b1, 11'd0, 11'd0}) begin
                    miscompares++;
                    $display("[TB] FAIL restart_first_pixel: got den=%b fs=%b x=%0d y=%0d expected 1 1 0 0",
                             den_s, fs_s, x_s, y_s);
                end
            end
        end
        vectors++;
        if (hd_bad != 0 || early != 0) begin
            miscompares++;
            $display("[TB] FAIL restart_timing: got %0d hd errors, %0d early den expected 0, 0", hd_bad, early);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL restart_model: %0d bad cycles, first got %h expected %h", bad, fa, fe);
        end
    endtask

    initial begin
        test_reset();
        test_default_timing();
        test_en_gap();
        test_random_en();
        test_two_frames();
        test_tracker();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
